// File: rtl/miner_pkg.sv
// Shared types and sizing constants for the miner work path (loader, nonce claim).
package miner_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } loader_state_t;

    localparam int WORK_WORDS = 24;
    localparam int MID_BITS   = 256;
    localparam int HEAD_BITS  = 512;

endpackage

// File: rtl/nonce_claim_reg.sv
// Latches the first winning nonce of a work unit and holds a claim flag until
// the memory manager acknowledges it or a new unit starts.
module nonce_claim_reg #(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ready,
    input  logic                 start,
    input  logic                 found,
    input  logic [DATAWIDTH-1:0] nonce,
    input  logic                 response,
    output logic                 claim,
    output logic [DATAWIDTH-1:0] claim_nonce
);

    // Clearing beats latching: a new unit or an acknowledge in the same cycle
    // as a find drops that nonce rather than re-arming the claim.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            claim       <= 1'b0;
            claim_nonce <= '0;
        end else if (start || response) begin
            claim <= 1'b0;
        end else if (found && ready && !claim) begin
            claim       <= 1'b1;
            claim_nonce <= nonce;
        end
    end

endmodule

// File: rtl/work_loader.sv
// Assembles a streamed 24-word work unit (midstate + header) into parallel
// vectors for the hash core and forwards the first winning nonce as a claim.
module work_loader
    import miner_pkg::*;
#(
    parameter int DATAWIDTH  = 32,
    parameter int MID_WORDS  = 8,
    parameter int HEAD_WORDS = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start_in,
    input  logic                            shift_in_enable,
    input  logic [DATAWIDTH-1:0]            data_in,
    output logic [MID_WORDS*DATAWIDTH-1:0]  midState,
    output logic [HEAD_WORDS*DATAWIDTH-1:0] headData,
    output logic                            work_valid,
    output logic                            work_start,
    output logic                            load_overrun,
    input  logic                            hash_found,
    input  logic [DATAWIDTH-1:0]            hash_nonce,
    output logic                            sol_claim,
    output logic [DATAWIDTH-1:0]            core_nonce,
    input  logic                            sol_response
);

    localparam int SR_BITS = MID_BITS + HEAD_BITS;
    localparam int CNT_W   = $clog2(WORK_WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MID_WORDS + HEAD_WORDS - 1);

    loader_state_t      state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [SR_BITS-1:0] sr, sr_next;
    logic               valid_next, start_next, overrun_next;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        sr_next      = sr;
        valid_next   = work_valid;
        start_next   = 1'b0;
        overrun_next = load_overrun;

        unique case (state)
            IDLE: begin
                if (start_in) begin
                    state_next   = LOAD;
                    cnt_next     = '0;
                    sr_next      = '0;
                    overrun_next = 1'b0;
                end
            end
            LOAD: begin
                if (start_in) begin
                    cnt_next = '0;
                    sr_next  = '0;
                end else if (shift_in_enable) begin
                    // Newest word enters at the top; word 0 ends up at bit 0.
                    sr_next  = {data_in, sr[SR_BITS-1:DATAWIDTH]};
                    cnt_next = cnt + 1'b1;
                    if (cnt == LAST_IDX) begin
                        state_next = READY;
                        valid_next = 1'b1;
                        start_next = 1'b1;
                    end
                end
            end
            READY: begin
                if (start_in) begin
                    state_next   = LOAD;
                    cnt_next     = '0;
                    sr_next      = '0;
                    valid_next   = 1'b0;
                    overrun_next = 1'b0;
                end else if (shift_in_enable) begin
                    overrun_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the shift register is a flop array, not a RAM, so it takes the
    // reset too; outputs must read zero and partial loads must vanish on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            sr           <= '0;
            work_valid   <= 1'b0;
            work_start   <= 1'b0;
            load_overrun <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            sr           <= sr_next;
            work_valid   <= valid_next;
            work_start   <= start_next;
            load_overrun <= overrun_next;
        end
    end

    assign midState = sr[MID_BITS-1:0];
    assign headData = sr[SR_BITS-1:MID_BITS];

    nonce_claim_reg #(
        .DATAWIDTH(DATAWIDTH)
    ) u_claim (
        .clk        (clk),
        .rst_n      (reset),
        .ready      (state == READY),
        .start      (start_in),
        .found      (hash_found),
        .nonce      (hash_nonce),
        .response   (sol_response),
        .claim      (sol_claim),
        .claim_nonce(core_nonce)
    );

endmodule

// File: tb/tb_work_loader.sv
// Scoreboard bench for work_loader: stimulus pushes expected work vectors and
// nonces; a negedge monitor pops them whenever the DUT announces a result.
module tb_work_loader;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_in;
    logic         shift_in_enable;
    logic [31:0]  data_in;
    logic [255:0] midState;
    logic [511:0] headData;
    logic         work_valid;
    logic         work_start;
    logic         load_overrun;
    logic         hash_found;
    logic [31:0]  hash_nonce;
    logic         sol_claim;
    logic [31:0]  core_nonce;
    logic         sol_response;

    always #5 clk = ~clk;

    work_loader dut (
        .clk            (clk),
        .reset          (reset),
        .start_in       (start_in),
        .shift_in_enable(shift_in_enable),
        .data_in        (data_in),
        .midState       (midState),
        .headData       (headData),
        .work_valid     (work_valid),
        .work_start     (work_start),
        .load_overrun   (load_overrun),
        .hash_found     (hash_found),
        .hash_nonce     (hash_nonce),
        .sol_claim      (sol_claim),
        .core_nonce     (core_nonce),
        .sol_response   (sol_response)
    );

    typedef struct packed {
        logic [255:0] mid;
        logic [511:0] head;
    } work_t;

    int           checks = 0;
    int           errors = 0;
    work_t        work_q[$];
    logic [31:0]  nonce_q[$];
    logic [31:0]  words[24];
    work_t        last_work;
    logic         prev_claim = 1'b0;
    logic [31:0]  n2;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference placement: word i<8 -> midState slot i, word 8+j -> headData slot j.
    function automatic work_t model();
        work_t r;
        r = '0;
        for (int i = 0; i < 24; i++) begin
            if (i < 8) r.mid[32*i +: 32] = words[i];
            else       r.head[32*(i-8) +: 32] = words[i];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            if (work_start) begin
                if (work_q.size() == 0) begin
                    check("unexpected_work_start", 1, 0);
                end else begin
                    work_t e;
                    e = work_q.pop_front();
                    check("sb_midState", midState, e.mid);
                    check("sb_headData", headData, e.head);
                    check("sb_work_valid", work_valid, 1);
                end
            end
            if (sol_claim && !prev_claim) begin
                if (nonce_q.size() == 0) begin
                    check("unexpected_claim", 1, 0);
                end else begin
                    check("sb_core_nonce", core_nonce, nonce_q.pop_front());
                end
            end
        end
        prev_claim = sol_claim;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
    endtask

    task automatic send(input logic [31:0] w);
        shift_in_enable = 1'b1;
        data_in         = w;
        tick();
        shift_in_enable = 1'b0;
        data_in         = $urandom;
    endtask

    // Streams words[] with random idle gaps and checks the completion timing.
    task automatic run_unit(input int max_gap);
        last_work = model();
        work_q.push_back(last_work);
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(max_gap, 0)) tick();
            check("valid_before_last", work_valid, 0);
            send(words[i]);
        end
        check("valid_after_last", work_valid, 1);
        check("start_after_last", work_start, 1);
        tick();
        check("start_one_cycle", work_start, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_midState"}, midState, 0);
        check({tag, "_headData"}, headData, 0);
        check({tag, "_work_valid"}, work_valid, 0);
        check({tag, "_work_start"}, work_start, 0);
        check({tag, "_load_overrun"}, load_overrun, 0);
        check({tag, "_sol_claim"}, sol_claim, 0);
        check({tag, "_core_nonce"}, core_nonce, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; start_in = 1'b0; shift_in_enable = 1'b0; data_in = '0;
        hash_found = 1'b0; hash_nonce = '0; sol_response = 1'b0;
        repeat (2) tick();
        check_all_zero("reset");
        reset = 1'b1;
        tick();

        // Ascending stream at full rate.
        pulse_start();
        for (int i = 0; i < 24; i++) words[i] = 32'(i);
        run_unit(0);
        check("mid_lo", midState[31:0], 32'h0);
        check("mid_hi", midState[255:224], 32'h7);
        check("head_lo", headData[31:0], 32'h8);
        check("head_hi", headData[511:480], 32'h17);

        // Same stream with gaps.
        pulse_start();
        run_unit(3);

        // Restart after 10 words; only the second set may appear.
        pulse_start();
        for (int i = 0; i < 10; i++) send($urandom);
        pulse_start();
        for (int i = 0; i < 24; i++) words[i] = 32'hA5A5_0000 + 32'(i);
        run_unit(1);

        // Overrun in READY.
        send(32'hDEADBEEF);
        check("overrun_set", load_overrun, 1);
        check("overrun_valid", work_valid, 1);
        check("overrun_mid", midState, last_work.mid);
        check("overrun_head", headData, last_work.head);
        pulse_start();
        check("overrun_cleared", load_overrun, 0);
        check("valid_cleared", work_valid, 0);
        for (int i = 0; i < 24; i++) words[i] = $urandom;
        run_unit(2);

        // Nonce claim handshake.
        hash_found = 1'b1; hash_nonce = 32'h1234ABCD;
        nonce_q.push_back(32'h1234ABCD);
        tick();
        hash_found = 1'b0;
        check("claim_set", sol_claim, 1);
        check("claim_nonce", core_nonce, 32'h1234ABCD);
        hash_found = 1'b1; hash_nonce = 32'h0BADF00D;
        tick();
        hash_found = 1'b0;
        check("second_find_claim", sol_claim, 1);
        check("second_find_nonce", core_nonce, 32'h1234ABCD);
        sol_response = 1'b1;
        tick();
        sol_response = 1'b0;
        check("ack_claim", sol_claim, 0);
        check("ack_nonce_kept", core_nonce, 32'h1234ABCD);

        // Find together with acknowledge: claim clears, nonce not taken.
        n2 = $urandom | 32'h1;
        hash_found = 1'b1; hash_nonce = n2;
        nonce_q.push_back(n2);
        tick();
        check("reclaim", sol_claim, 1);
        hash_nonce = ~n2; sol_response = 1'b1;
        tick();
        hash_found = 1'b0; sol_response = 1'b0;
        check("find_ack_claim", sol_claim, 0);
        check("find_ack_nonce", core_nonce, n2);

        // Find together with start: start wins; finds in LOAD are ignored.
        hash_found = 1'b1; hash_nonce = 32'hCAFE0001; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        check("find_start_claim", sol_claim, 0);
        check("find_start_nonce", core_nonce, n2);
        tick();
        hash_found = 1'b0;
        check("find_in_load", sol_claim, 0);

        // Asynchronous reset in the middle of a load.
        for (int i = 0; i < 5; i++) send($urandom | 32'h1);
        check("partial_nonzero", (headData != 0), 1);
        #2 reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        reset = 1'b1;
        tick();

        check("work_q_drained", work_q.size(), 0);
        check("nonce_q_drained", nonce_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
